dsp_mac_pipe: RTL and testbench

Parametrised successor to the FB42 single-lane DSP multiply-accumulate model. It adds a valid/ready handshake and a configurable-depth, stallable output pipeline. It also adds a dual-lane SIMD mode. MAC chaining is tied to accepted transactions, not to clock cycles. It sits between the operand sequencer and the result collector in the FB42DSP datapath.

---
 rtl/dsp_mac_pkg.sv | 58 +++++
 rtl/dsp_pipe_stage.sv | 24 ++
 rtl/dsp_mac_pipe.sv | 121 ++++++++++++
 tb/tb_dsp_mac_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Mode codes and lane arithmetic helpers shared by dsp_mac_pipe.
// DSP_MAC_SAT_EN switches lane sums (and left shifts) from wrap-around to saturation.
package dsp_mac_pkg;

    localparam logic [1:0] MODE_HALF  = 2'b00;
    localparam logic [1:0] MODE_MIXED = 2'b01;
    localparam logic [1:0] MODE_FULL  = 2'b10;
    localparam logic [1:0] MODE_SIMD2 = 2'b11;

    // Lane math is done in a wide signed container; lanes up to 2*30 bits plus shift fit.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t sext(input calc_t x, input int unsigned lw);
        calc_t t;
        t = x << (CALC_W - lw);
        return t >>> (CALC_W - lw);
    endfunction

    function automatic calc_t sat_max(input int unsigned lw);
        return (calc_t'(1) << (lw - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(input int unsigned lw);
        return -(calc_t'(1) << (lw - 1));
    endfunction

    function automatic calc_t sat_clamp(input calc_t v, input int unsigned lw);
        if (v > sat_max(lw)) return sat_max(lw);
        if (v < sat_min(lw)) return sat_min(lw);
        return v;
    endfunction

    // Unbounded shift of a lane value; the caller wraps or clamps the result.
    function automatic calc_t shift_val(input calc_t x, input logic dir,
                                        input int unsigned amt, input int unsigned lw);
        calc_t v;
        v = sext(x, lw);
        return dir ? (v >>> amt) : (v << amt);
    endfunction

    // One lane of the accumulator update; only the low lw bits of the result are meaningful.
    function automatic calc_t lane_mac(input calc_t acc_l, input calc_t prod_l, input calc_t cc_l,
                                       input logic chain, input logic sh_en, input logic sh_dir,
                                       input int unsigned amt, input int unsigned lw);
        calc_t base;
        if (!chain)      base = sext(cc_l, lw);
        else if (sh_en)  base = shift_val(acc_l, sh_dir, amt, lw);
        else             base = sext(acc_l, lw);
`ifdef DSP_MAC_SAT_EN
        base = sat_clamp(base, lw);
        return sat_clamp(sext(prod_l, lw) + base, lw);
`else
        return sext(prod_l, lw) + base;
`endif
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One data+valid register of the output pipeline, advancing only when load is high.
module dsp_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Handshaked multiply-accumulate with SIMD2 mode and a stallable output pipeline.
// Build with DSP_MAC_SAT_EN defined for saturating accumulation.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SHIFT_BITS  = 2,
    parameter int PIPE_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      aa,
    input  logic [WIDTH-1:0]      bb,
    input  logic [2*WIDTH-1:0]    cc,
    input  logic [1:0]            mode,
    input  logic                  mac,
    input  logic                  shift_enable,
    input  logic                  shift_dir,
    input  logic [SHIFT_BITS-1:0] shift_amount,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out
);

    localparam int W2 = WIDTH / 2;
    localparam int AW = 2 * WIDTH;

    logic          adv, accept, chain;
    logic [AW-1:0] acc, acc_next;
    logic          acc_valid, mac_prev;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign chain    = mac && mac_prev;

    // Operands are sign-extended to the product width so plain multiplies give signed results.
    logic [AW-1:0]    aa_half, bb_half, aa_full, bb_full, aa_sel, bb_sel, prod_full;
    logic [WIDTH-1:0] aa_lo, bb_lo, aa_hi, bb_hi, prod_lo, prod_hi;

    assign aa_half = {{(AW-W2-1){aa[W2]}}, aa[W2:0]};
    assign bb_half = {{(AW-W2-1){bb[W2]}}, bb[W2:0]};
    assign aa_full = {{WIDTH{aa[WIDTH-1]}}, aa};
    assign bb_full = {{WIDTH{bb[WIDTH-1]}}, bb};
    assign aa_sel  = (mode == MODE_FULL) ? aa_full : aa_half;
    assign bb_sel  = (mode == MODE_HALF) ? bb_half : bb_full;
    assign prod_full = aa_sel * bb_sel;

    assign aa_lo = {{(WIDTH-W2){aa[W2-1]}}, aa[W2-1:0]};
    assign bb_lo = {{(WIDTH-W2){bb[W2-1]}}, bb[W2-1:0]};
    assign aa_hi = {{(WIDTH-W2){aa[WIDTH-1]}}, aa[WIDTH-1:W2]};
    assign bb_hi = {{(WIDTH-W2){bb[WIDTH-1]}}, bb[WIDTH-1:W2]};
    assign prod_lo = aa_lo * bb_lo;
    assign prod_hi = aa_hi * bb_hi;

    function automatic calc_t ext_full(input logic [AW-1:0] v);
        return {{(CALC_W-AW){1'b0}}, v};
    endfunction

    function automatic calc_t ext_lane(input logic [WIDTH-1:0] v);
        return {{(CALC_W-WIDTH){1'b0}}, v};
    endfunction

    calc_t       full_res, lo_res, hi_res;
    logic [31:0] amt;
    logic        unused_res_bits;

    assign amt = 32'(shift_amount);

    always_comb begin
        full_res = lane_mac(ext_full(acc), ext_full(prod_full), ext_full(cc),
                            chain, shift_enable, shift_dir, amt, AW);
        lo_res   = lane_mac(ext_lane(acc[WIDTH-1:0]), ext_lane(prod_lo), ext_lane(cc[WIDTH-1:0]),
                            chain, shift_enable, shift_dir, amt, WIDTH);
        hi_res   = lane_mac(ext_lane(acc[AW-1:WIDTH]), ext_lane(prod_hi), ext_lane(cc[AW-1:WIDTH]),
                            chain, shift_enable, shift_dir, amt, WIDTH);
        acc_next = (mode == MODE_SIMD2) ? {hi_res[WIDTH-1:0], lo_res[WIDTH-1:0]}
                                        : full_res[AW-1:0];
    end

    assign unused_res_bits = ^{full_res[CALC_W-1:AW], lo_res[CALC_W-1:WIDTH], hi_res[CALC_W-1:WIDTH]};

    // acc keeps its data after advancing out so a later chained beat can still use it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            acc_valid <= 1'b0;
            mac_prev  <= 1'b0;
        end else if (adv) begin
            acc_valid <= accept;
            if (accept) begin
                acc      <= acc_next;
                mac_prev <= mac;
            end
        end
    end

    logic [AW-1:0] stage_data  [PIPE_STAGES+1];
    logic          stage_valid [PIPE_STAGES+1];

    assign stage_data[0]  = acc;
    assign stage_valid[0] = acc_valid;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        dsp_pipe_stage #(.WIDTH(AW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (adv),
            .d       (stage_data[i]),
            .d_valid (stage_valid[i]),
            .q       (stage_data[i+1]),
            .q_valid (stage_valid[i+1])
        );
    end

    assign out       = stage_data[PIPE_STAGES];
    assign out_valid = stage_valid[PIPE_STAGES];

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: directed plan items plus randomized beats and back-pressure.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;

    localparam int WIDTH = 16;
    localparam int SB    = 2;
    localparam int PS    = 3;

    logic          clk = 1'b0, rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [15:0]   aa = '0, bb = '0;
    logic [31:0]   cc = '0;
    logic [1:0]    mode = '0;
    logic          mac = 1'b0, shift_enable = 1'b0, shift_dir = 1'b0;
    logic [SB-1:0] shift_amount = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [31:0]   out;

    int errors = 0, checks = 0, accepted = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    longint      m_acc = 0;
    bit          m_mac_prev = 0;
    bit          rand_ready = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.WIDTH(WIDTH), .SHIFT_BITS(SB), .PIPE_STAGES(PS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aa(aa), .bb(bb), .cc(cc), .mode(mode), .mac(mac),
        .shift_enable(shift_enable), .shift_dir(shift_dir), .shift_amount(shift_amount),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    // Reference model: signed integer arithmetic on whole lanes.
    function automatic longint sx(input longint v, input int bits);
        return (v <<< (64 - bits)) >>> (64 - bits);
    endfunction

    function automatic longint fit(input longint v, input int bits);
`ifdef DSP_MAC_SAT_EN
        longint hi, lo;
        hi = (longint'(1) << (bits - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        return sx(v, bits);
`endif
    endfunction

    function automatic longint lane(input longint acc_l, input longint prod, input longint cc_l,
                                    input bit chain, input bit se, input bit dir,
                                    input int amt, input int bits);
        longint base;
        if (!chain)   base = sx(cc_l, bits);
        else if (!se) base = sx(acc_l, bits);
        else if (dir) base = sx(acc_l, bits) >>> amt;
        else          base = fit(sx(acc_l, bits) * (longint'(1) << amt), bits);
        return fit(prod + base, bits) & ((longint'(1) << bits) - 1);
    endfunction

    function automatic logic [31:0] model_step(input longint a, input longint b, input longint c,
                                               input int md, input bit mc, input bit se,
                                               input bit sd, input int sa);
        bit     chain;
        longint p, r, lo, hi;
        chain = mc && m_mac_prev;
        if (md == 3) begin
            lo = lane(m_acc & 16'hFFFF, sx(a, 8) * sx(b, 8), c & 16'hFFFF, chain, se, sd, sa, 16);
            hi = lane((m_acc >> 16) & 16'hFFFF, sx(a >> 8, 8) * sx(b >> 8, 8),
                      (c >> 16) & 16'hFFFF, chain, se, sd, sa, 16);
            r = (hi << 16) | lo;
        end else begin
            if (md == 0)      p = sx(a, 9) * sx(b, 9);
            else if (md == 1) p = sx(a, 9) * sx(b, 16);
            else              p = sx(a, 16) * sx(b, 16);
            r = lane(m_acc, p, c, chain, se, sd, sa, 32);
        end
        m_acc      = r;
        m_mac_prev = mc;
        return 32'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat until accepted; use_k pushes a fixed expected value instead of the model's.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                        input logic [1:0] md, input logic mc, input logic se, input logic sd,
                        input logic [1:0] sa, input bit use_k, input logic [31:0] k);
        logic [31:0] mexp;
        int tries;
        tries = 0;
        aa = a; bb = b; cc = c; mode = md; mac = mc;
        shift_enable = se; shift_dir = sd; shift_amount = sa;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && tries < 300) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        mexp = model_step(a, b, c, md, mc, se, sd, sa);
        exp_q.push_back(use_k ? k : mexp);
        accepted++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'b0, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got=%h required=none", out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out !== mon_exp) begin
                    errors++;
                    $display("FAIL result got=%h required=%h", out, mon_exp);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", out, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        idle(1);

        // Plan 1: latency and single-cycle valid
        send(16'hFFFE, 16'd3, 32'd10, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h00000004);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", k), 32'(out_valid), 32'(k == 4));
        end
        idle(1);

        // Plan 2: chaining, idle gap, shifts
        send(16'd5, 16'd7, 32'd1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd36);
        send(16'd2, 16'd3, $urandom, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd42);
        idle(2);
        send(16'd1, 16'd1, $urandom, 2'b00, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'd22);
        send(16'd1, 16'd1, $urandom, 2'b00, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'd45);

        // Plan 3: half-operand truncation and SIMD lanes
        send(16'h01FF, 16'h0002, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFE);
        send(16'h03FE, 16'h0405, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000CFFF6);
        drain();

        // Plan 4: back-pressure capacity and gapless drain
        out_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
            end
        join_none
        idle(12);
        chk("bp_accepted", 32'(accepted - acc0), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("bp_flow_%0d", k), 32'(out_valid), 32'd1);
        end
        wait fork;
        drain();

        // Plan 5: asynchronous reset with the pipeline full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'h1234 + 16'(i), 16'h0101, 32'h55, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_acc      = 0;
        m_mac_prev = 0;
        out_ready  = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        idle(1);
        send(16'd2, 16'd2, 32'd5, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd9);

        // Plan 6: left-shift overflow, wrap or saturate
        send(16'h7, 16'h9, $urandom, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        send(16'h8000, 16'h8000, 32'd0, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h40000000);
`ifdef DSP_MAC_SAT_EN
        send(16'h8000, 16'h8000, $urandom, 2'b10, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h7FFFFFFF);
`else
        send(16'h8000, 16'h8000, $urandom, 2'b10, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'hC0000000);
`endif
        drain();

        // Random beats under random back-pressure
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        rand_ready = 0;
        out_ready  = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
